// File: rtl/pipe_halt_ctrl.sv
// pipe_halt_ctrl: halt/valid sequencer for a chain of halt-gated register
// stages. It tracks one valid bit per stage and collapses bubbles. It also
// drives the upstream ready and downstream valid signals, and runs a timed
// pipeline flush.
// Optional statistics counter: define PIPE_HALT_CTRL_STATS_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal operation, data advances into free slots
// ST_FLUSH | pipe emptied, all stages halted, counter times the flush
module pipe_halt_ctrl #(
   parameter int STAGES       = 3,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              i_valid,
   input  logic              i_ready,
   input  logic              i_flush,
   input  logic              i_stat_clr,
   output logic [STAGES-1:0] o_halt,
   output logic [STAGES-1:0] o_valid,
   output logic              o_ready,
   output logic              o_out_valid,
   output logic              o_busy,
   output logic [CNT_W-1:0]  o_stall_cnt
);

   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   state_t            state, state_nxt;
   logic [FC_W-1:0]   flush_cnt, flush_cnt_nxt;
   logic [STAGES-1:0] halt_run;
   logic [STAGES-1:0] valid_nxt;
   logic              flushing;

   // A stage halts only when it holds a word and every stage below it is
   // also blocked. Built as a running AND from the last stage upward, so
   // there is no combinational loop on halt_run itself.
   always_comb begin
      logic acc;
      halt_run = '0;
      acc      = ~i_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         acc         = acc & o_valid[k];
         halt_run[k] = acc;
      end
   end

   // Pipe-facing outputs. A flush request blocks all transfers in the
   // same cycle, before the FSM has left RUN.
   always_comb begin
      flushing    = (state == ST_FLUSH) | i_flush;
      o_halt      = flushing ? '1 : halt_run;
      o_ready     = ~flushing & ~halt_run[0];
      o_out_valid = ~flushing & o_valid[STAGES-1];
      o_busy      = (state == ST_FLUSH);
   end

   // Next valid bits. A stage that is not halted takes the valid bit of the
   // stage above it; upstream i_valid feeds stage 0.
   always_comb begin
      logic prev;
      valid_nxt = '0;
      prev      = i_valid;
      for (int k = 0; k < STAGES; k++) begin
         valid_nxt[k] = halt_run[k] ? o_valid[k] : prev;
         prev         = o_valid[k];
      end
      if (flushing) valid_nxt = '0;
   end

   // FSM next state and flush timer. A flush request while already
   // flushing reloads the timer, which extends the flush.
   always_comb begin
      state_nxt     = state;
      flush_cnt_nxt = flush_cnt;
      case (state)
         ST_RUN: begin
            if (i_flush) begin
               state_nxt     = ST_FLUSH;
               flush_cnt_nxt = FC_LOAD;
            end
         end
         ST_FLUSH: begin
            if (i_flush) begin
               flush_cnt_nxt = FC_LOAD;
            end else if (flush_cnt == '0) begin
               state_nxt = ST_RUN;
            end else begin
               flush_cnt_nxt = flush_cnt - 1'b1;
            end
         end
         default: begin
            state_nxt     = ST_RUN;
            flush_cnt_nxt = '0;
         end
      endcase
   end

   // State, timer and valid registers.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state     <= ST_RUN;
         flush_cnt <= '0;
         o_valid   <= '0;
      end else begin
         state     <= state_nxt;
         flush_cnt <= flush_cnt_nxt;
         o_valid   <= valid_nxt;
      end
   end

`ifdef PIPE_HALT_CTRL_STATS_EN
   logic stall_evt;

   assign stall_evt = (state == ST_RUN) & o_out_valid & ~i_ready;

   // Saturating count of cycles where downstream refused a valid word.
   // A clear request wins over an increment in the same cycle.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         o_stall_cnt <= '0;
      end else if (i_stat_clr) begin
         o_stall_cnt <= '0;
      end else if (stall_evt && (o_stall_cnt != '1)) begin
         o_stall_cnt <= o_stall_cnt + 1'b1;
      end
   end
`else
   logic unused_stat_clr;

   assign unused_stat_clr = i_stat_clr;
   assign o_stall_cnt     = '0;
`endif

endmodule

// File: tb/tb_pipe_halt_ctrl.sv
// Directed bench for pipe_halt_ctrl (STAGES=3, FLUSH_CYCLES=2, CNT_W=3).
module tb_pipe_halt_ctrl;

   localparam int STAGES       = 3;
   localparam int FLUSH_CYCLES = 2;
   localparam int CNT_W        = 3;

   logic              clk = 1'b0;
   logic              arst;
   logic              i_valid, i_ready, i_flush, i_stat_clr;
   logic [STAGES-1:0] o_halt, o_valid;
   logic              o_ready, o_out_valid, o_busy;
   logic [CNT_W-1:0]  o_stall_cnt;

   int n_cmp = 0;
   int n_mis = 0;

   pipe_halt_ctrl #(
      .STAGES(STAGES), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .arst(arst), .i_valid(i_valid), .i_ready(i_ready),
      .i_flush(i_flush), .i_stat_clr(i_stat_clr), .o_halt(o_halt),
      .o_valid(o_valid), .o_ready(o_ready), .o_out_valid(o_out_valid),
      .o_busy(o_busy), .o_stall_cnt(o_stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // advance one rising edge, then settle 1 time unit past it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      arst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_flush = 1'b0; i_stat_clr = 1'b0;
      #2;
      chk("rst_valid", 32'(o_valid), 32'h0);
      chk("rst_halt", 32'(o_halt), 32'h0);
      chk("rst_ready", 32'(o_ready), 32'h1);
      chk("rst_outv", 32'(o_out_valid), 32'h0);
      chk("rst_busy", 32'(o_busy), 32'h0);
      chk("rst_stall", 32'(o_stall_cnt), 32'h0);
      #10 arst = 1'b0;
      step();

      // 1: fill at full throughput
      i_valid = 1'b1; i_ready = 1'b1; #1;
      chk("fill_halt0", 32'(o_halt), 32'h0);
      chk("fill_ready0", 32'(o_ready), 32'h1);
      step(); chk("fill_v1", 32'(o_valid), 32'b001); chk("fill_outv1", 32'(o_out_valid), 32'h0);
      step(); chk("fill_v2", 32'(o_valid), 32'b011); chk("fill_halt2", 32'(o_halt), 32'h0);
      step(); chk("fill_v3", 32'(o_valid), 32'b111); chk("fill_outv3", 32'(o_out_valid), 32'h1);
      chk("fill_ready3", 32'(o_ready), 32'h1);
      step(); chk("full_thru_v", 32'(o_valid), 32'b111); chk("full_thru_rdy", 32'(o_ready), 32'h1);

      // 2: downstream stall on a full pipe, then release
      i_ready = 1'b0; #1;
      chk("stall_halt", 32'(o_halt), 32'b111);
      chk("stall_ready", 32'(o_ready), 32'h0);
      step(); chk("stall_hold1", 32'(o_valid), 32'b111);
      step(); chk("stall_hold2", 32'(o_valid), 32'b111);
      i_ready = 1'b1; #1;
      chk("rel_halt", 32'(o_halt), 32'h0);
      chk("rel_ready", 32'(o_ready), 32'h1);
      i_valid = 1'b0;
      step(); chk("drain1", 32'(o_valid), 32'b110);
      step(); chk("drain2", 32'(o_valid), 32'b100);
      chk("drain2_outv", 32'(o_out_valid), 32'h1);
      step(); chk("drain3", 32'(o_valid), 32'b000);
      chk("drain3_outv", 32'(o_out_valid), 32'h0);

      // 3: bubble collapse, build 101 then stall downstream
      i_valid = 1'b1; step();
      i_valid = 1'b0; step();
      i_valid = 1'b1; step();
      chk("bub_v", 32'(o_valid), 32'b101);
      i_ready = 1'b0; #1;
      chk("bub_halt", 32'(o_halt), 32'b100);
      chk("bub_ready", 32'(o_ready), 32'h1);
      step(); chk("bub_after", 32'(o_valid), 32'b111);

      // 4: flush from a full pipe, then a flush extended in its last cycle
      i_valid = 1'b0; i_flush = 1'b1; #1;
      chk("fl_outv", 32'(o_out_valid), 32'h0);
      chk("fl_halt", 32'(o_halt), 32'b111);
      chk("fl_ready", 32'(o_ready), 32'h0);
      chk("fl_busy0", 32'(o_busy), 32'h0);
      step(); i_flush = 1'b0; #1;
      chk("fl_v", 32'(o_valid), 32'b000);
      chk("fl_busy1", 32'(o_busy), 32'h1);
      step(); chk("fl_busy2", 32'(o_busy), 32'h1);
      chk("fl_rdy2", 32'(o_ready), 32'h0);
      step(); chk("fl_busy3", 32'(o_busy), 32'h0);
      chk("fl_rdy3", 32'(o_ready), 32'h1);
      i_flush = 1'b1; step(); i_flush = 1'b0; #1;
      chk("ext_busy1", 32'(o_busy), 32'h1);
      step(); chk("ext_busy2", 32'(o_busy), 32'h1);
      i_flush = 1'b1; i_valid = 1'b1; step(); i_flush = 1'b0; #1;
      chk("ext_busy3", 32'(o_busy), 32'h1);
      chk("ext_ign_v", 32'(o_valid), 32'b000);
      step(); chk("ext_busy4", 32'(o_busy), 32'h1);
      chk("ext_ign_v2", 32'(o_valid), 32'b000);
      i_valid = 1'b0;
      step(); chk("ext_busy5", 32'(o_busy), 32'h0);
      chk("ext_v5", 32'(o_valid), 32'b000);

      // 5: asynchronous reset during a stall
      i_ready = 1'b0; i_valid = 1'b1;
      step(); step(); step();
      chk("ar_pre_v", 32'(o_valid), 32'b111);
      chk("ar_pre_halt", 32'(o_halt), 32'b111);
      #2 arst = 1'b1; #1;
      chk("ar_v", 32'(o_valid), 32'b000);
      chk("ar_halt", 32'(o_halt), 32'b000);
      chk("ar_ready", 32'(o_ready), 32'h1);
      #2 arst = 1'b0;
      step(); step(); step();
      chk("ar_refill", 32'(o_valid), 32'b111);

      // 6: stall statistics (pipe full, i_ready=0)
      i_stat_clr = 1'b1; step(); i_stat_clr = 1'b0;
      chk("st_clr0", 32'(o_stall_cnt), 32'h0);
      for (int i = 0; i < 5; i++) step();
`ifdef PIPE_HALT_CTRL_STATS_EN
      chk("st_5", 32'(o_stall_cnt), 32'h5);
      for (int i = 0; i < 5; i++) step();
      chk("st_sat", 32'(o_stall_cnt), 32'h7);
      i_stat_clr = 1'b1; step(); i_stat_clr = 1'b0;
      chk("st_clr", 32'(o_stall_cnt), 32'h0);
`else
      chk("st_5_off", 32'(o_stall_cnt), 32'h0);
      for (int i = 0; i < 5; i++) step();
      chk("st_10_off", 32'(o_stall_cnt), 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
